// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared constants and state encoding for the round-robin mux arbiter
package rr_mux_pkg;

    localparam int N_REQ           = 8;
    localparam int SEL_W           = 3;
    localparam int HOLD_CYCLES_DEF = 4;
    // Wide enough for the largest legal hold limit (15)
    localparam int CNT_W           = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - requester bank / consumer bundle for the round-robin mux arbiter
interface rr_mux_arbiter_if;
    import rr_mux_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] din;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             y;
    logic             y_valid;

    // Requester bank / environment side
    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  y,
        input  y_valid
    );

    // Arbiter side
    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output y,
        output y_valid
    );

endinterface

// File: rtl/mux81.sv
// rtl/mux81.sv - 8:1 single-bit multiplexer datapath
module mux81 (
    input  logic [7:0] din,
    input  logic [2:0] sel,
    output logic       y
);

    assign y = din[sel];

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority encoder: first requester at or after ptr, wrapping
module rr_pick
    import rr_mux_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    // Scan from farthest to nearest so the candidate closest to ptr overwrites the rest
    always_comb begin
        logic [SEL_W-1:0] idx;
        winner = '0;
        any    = |req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin owner scheduling over a shared mux81 datapath
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    rr_mux_arbiter_if.slave  bus
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             y_q, y_d;
    logic             y_valid_q, y_valid_d;

    logic [SEL_W-1:0] after_owner;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic             release_now;
    logic             mux_y;

    // sel_q always holds the current owner while granting
    assign after_owner = sel_q + SEL_W'(1);

    // On release the new search starts just past the owner, making it the last candidate
    assign pick_ptr    = (state_q == ST_GRANT) ? after_owner : ptr_q;

    assign release_now = !bus.req[sel_q] || (cnt_q == CNT_W'(HOLD_CYCLES - 1));

    rr_pick u_pick (
        .req    (bus.req),
        .ptr    (pick_ptr),
        .winner (winner),
        .any    (any_req)
    );

    mux81 u_mux (
        .din (bus.din),
        .sel (sel_q),
        .y   (mux_y)
    );

    // Next-state, ownership and datapath computation
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        y_valid_d = |gnt_q;
        y_d       = (|gnt_q) ? mux_y : y_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_GRANT;
                    gnt_d   = N_REQ'(1) << winner;
                    sel_d   = winner;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (release_now) begin
                    ptr_d = after_owner;
                    if (any_req) begin
                        gnt_d = N_REQ'(1) << winner;
                        sel_d = winner;
                        cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any burst with no pending output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            sel_q     <= '0;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - randomized and directed checks of rr_mux_arbiter against a behavioural model
module tb_rr_mux_arbiter;
    import rr_mux_pkg::*;

    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    rr_mux_arbiter_if bus ();

    rr_mux_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: who owns the bus, for how many cycles, and where the search resumes
    bit         m_busy;
    int         m_owner;
    int         m_ptr;
    int         m_held;
    logic [7:0] m_gnt;
    logic [2:0] m_sel;
    logic       m_y;
    logic       m_yv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_gnt   = 8'h00;
        m_sel   = 3'd0;
        m_y     = 1'b0;
        m_yv    = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic [7:0] d);
        logic ny, nyv;
        nyv = (m_gnt != 8'h00);
        ny  = nyv ? d[m_sel] : m_y;
        if (!m_busy) begin
            if (r != 8'h00) begin
                m_busy  = 1'b1;
                m_owner = pick(r, m_ptr);
                m_held  = 1;
            end
        end else if (!r[m_owner] || m_held == HOLD) begin
            m_ptr = (m_owner + 1) % 8;
            if (r != 8'h00) begin
                m_owner = pick(r, m_ptr);
                m_held  = 1;
            end else begin
                m_busy = 1'b0;
            end
        end else begin
            m_held++;
        end
        m_gnt = m_busy ? (8'h01 << m_owner) : 8'h00;
        if (m_busy) m_sel = 3'(m_owner);
        m_y  = ny;
        m_yv = nyv;
    endtask

    task automatic compare_all();
        chk("gnt", bus.gnt, m_gnt);
        chk("sel", bus.sel, m_sel);
        chk("y", bus.y, m_y);
        chk("y_valid", bus.y_valid, m_yv);
    endtask

    // Drive after the falling edge, model the rising edge, compare at the next falling edge
    task automatic cycle(input logic [7:0] r, input logic [7:0] d);
        bus.req = r;
        bus.din = d;
        @(posedge clk);
        model_step(r, d);
        @(negedge clk);
        compare_all();
    endtask

    // Mid-cycle asynchronous reset: outputs must clear without any clock edge
    task automatic mid_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt", bus.gnt, 8'h00);
        chk("rst_sel", bus.sel, 3'd0);
        chk("rst_y", bus.y, 1'b0);
        chk("rst_y_valid", bus.y_valid, 1'b0);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        int         hold_len;

        rst     = 1'b1;
        bus.req = 8'h00;
        bus.din = 8'h00;
        #1;
        chk("por_gnt", bus.gnt, 8'h00);
        chk("por_sel", bus.sel, 3'd0);
        chk("por_y", bus.y, 1'b0);
        chk("por_y_valid", bus.y_valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Single requester, re-granted back-to-back
        cycle(8'h04, 8'hBD);
        chk("single_gnt", bus.gnt, 8'h04);
        chk("single_sel", bus.sel, 3'd2);
        cycle(8'h04, 8'hBD);
        chk("single_y", bus.y, 1'b1);
        chk("single_y_valid", bus.y_valid, 1'b1);
        repeat (8) cycle(8'h04, 8'hBD);
        chk("single_regrant", bus.gnt, 8'h04);

        // Mid-burst reset, then quiet with req low
        mid_reset();
        repeat (3) cycle(8'h00, 8'hFF);

        // All requesting from reset: owners 0..7,0 each for HOLD cycles
        mid_reset();
        repeat (8 * HOLD + 4) cycle(8'hFF, 8'b1011_1101);

        // Early release wrapping from ptr 4 to owner 1
        mid_reset();
        cycle(8'h08, 8'h00);
        chk("early_own3", bus.sel, 3'd3);
        cycle(8'h08, 8'h00);
        cycle(8'h02, 8'h02);
        chk("early_sel", bus.sel, 3'd1);
        chk("early_gnt", bus.gnt, 8'h02);
        repeat (2) cycle(8'h02, 8'h02);

        // Rotation skip: bring ptr to 6, then alternate 6 and 0
        cycle(8'h20, 8'h41);
        cycle(8'h41, 8'h41);
        chk("rot_first6", bus.sel, 3'd6);
        repeat (2 * HOLD + 2) cycle(8'h41, 8'h41);

        // Go idle: gnt clears, y_valid one edge later, sel holds
        cycle(8'h00, 8'h00);
        chk("idle_gnt", bus.gnt, 8'h00);
        cycle(8'h00, 8'h00);
        chk("idle_y_valid", bus.y_valid, 1'b0);
        chk("idle_sel_hold", bus.sel, 3'd6);

        // Randomized stretches of request patterns with occasional resets
        for (int seg = 0; seg < 120; seg++) begin
            case ($urandom_range(0, 5))
                0:       r = 8'h00;
                1:       r = 8'h01 << $urandom_range(0, 7);
                2:       r = 8'($urandom());
                default: r = 8'($urandom()) & 8'($urandom());
            endcase
            hold_len = $urandom_range(1, 7);
            for (int c = 0; c < hold_len; c++) begin
                cycle(r, 8'($urandom()));
            end
            if ($urandom_range(0, 39) == 0) mid_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin scheduler that shares the 1-bit mux81 datapath (din[7:0], sel[2:0] -> y) between 8 requesters.
- Requester i owns mux input din[i]. The block grants one requester at a time, drives sel to the owner's index and emits the registered mux output with a valid strobe.
- Sits between the requester bank and the serial output consumer. Instantiates mux81 as its datapath.

Parameters:
- N_REQ, 8, number of requesters; fixed to mux81 width, other values unsupported.
- SEL_W, 3, select width, log2(N_REQ).
- HOLD_CYCLES, 4, maximum consecutive grant cycles per ownership; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  8  request per requester; level-sensitive.
- din  in  8  data bits; din[i] belongs to requester i.
- gnt  out 8  one-hot grant, registered; all-zero when idle.
- sel  out 3  registered index of the current owner; drives the mux81 sel.
- y  out 1  registered mux output, din[owner] sampled one cycle earlier.
- y_valid  out 1  high when y carries a bit from a granted cycle.

Behaviour:
- Reset (async, rst=1) values: gnt=0, sel=0, y=0, y_valid=0, ptr=0, cnt=0, state=IDLE. Mid-burst reset aborts immediately, with no pending output.
- States: IDLE, GRANT.
- Winner selection (combinational): first index with req=1 searching ptr, ptr+1, … wrapping mod 8.
- IDLE: if |req at an edge, go to GRANT with owner=winner. gnt=1<<winner, sel=winner, cnt=0. Latency is one edge from req sampled to gnt.
- GRANT, each edge:
  - cnt increments.
  - Release condition: req[owner]==0, or cnt==HOLD_CYCLES-1.
  - On release, ptr<=owner+1 (wrap 7->0). The next winner is computed against that new ptr on the same edge.
    - If any req is set (the owner included), move directly to GRANT with the new owner and cnt=0. No idle bubble.
    - Otherwise go to IDLE and clear gnt.
- Fairness: the owner is the last candidate after release, so it is re-granted back-to-back only if it is the sole requester.
- Datapath: y<=mux81(din, sel) and y_valid<=|gnt every edge. Valid data therefore trails gnt by exactly one cycle. y holds its last value when y_valid=0.
- Invariants: gnt is always one-hot or zero. sel==index(gnt) whenever gnt!=0. sel holds its last value in IDLE.
- din changes are sampled every cycle; there is no capture of din at grant time.

Decomposition:
- Shared package rr_mux_pkg: N_REQ, SEL_W, HOLD_CYCLES default, and the state encodings ST_IDLE/ST_GRANT.
- Sub-module rr_pick: rotating-priority encoder with inputs req[7:0] and ptr[2:0], and outputs winner[2:0] and any. It is purely combinational.
- The existing mux81 is instantiated unchanged as the datapath.

Test Plan:
- Reset: assert rst mid-cycle during a GRANT -> gnt=0, sel=0, y=0, y_valid=0 immediately without a clock edge; after release with req=0 the outputs stay 0.
- Single requester: req=8'b0000_0100, din=8'hBD -> gnt=8'h04 one edge later, sel=2, y=1 with y_valid=1 one further edge. After 4 grant cycles owner 2 is re-granted with no gnt gap and cnt restarts.
- All request from reset: req=8'hFF, din=8'b1011_1101, HOLD_CYCLES=4 -> owners 0,1,…,7,0, each for 4 cycles. The y sequence (per owner, repeated 4×) is 1,0,1,1,1,1,0,1.
- Early release: owner 3 granted, req[3] drops after 2 cycles while req=8'b0000_0010 -> the next edge grants owner 1 (search from ptr=4 wraps to 1), sel=1, with no idle cycle.
- Rotation skip: ptr=6 with req=8'b0100_0001 -> owner 6 is granted first, then owner 0, then owner 6 again; bit 7 is never granted.
- Go idle: the sole owner drops req and all req=0 -> gnt=0 on the next edge, y_valid=0 one edge after that, sel holds the last index.
